controle_horner: RTL

Parametrised control unit for the polynomial-evaluation datapath. It sequences Horner's rule, S = (((a_N·x + a_(N-1))·x + …)·x + a_0), over GRAU+1 coefficients. It drives the X/S/product register loads, the S source mux, the coefficient address and the multiplier enable. Compared with the fixed 8-step controller it supports any degree and a multi-cycle multiplier, and it uses a full start/done handshake.

---
 rtl/controle_horner_if.sv | 27 ++
 rtl/controle_horner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/controle_horner_if.sv
// Control bus between the Horner sequencer and the polynomial datapath.
//   master : the sequencer (receives inicio, drives loads/selects/status)
//   slave  : the datapath / requester side
// Ports: inicio, LX, LS, LP, H, M_S, IDX[IDX_W-1:0], ocupado, pronto.
interface controle_horner_if #(
  parameter int unsigned IDX_W = 2
);
  logic             inicio;
  logic             LX;
  logic             LS;
  logic             LP;
  logic             H;
  logic             M_S;
  logic [IDX_W-1:0] IDX;
  logic             ocupado;
  logic             pronto;

  modport master (
    input  inicio,
    output LX, LS, LP, H, M_S, IDX, ocupado, pronto
  );

  modport slave (
    output inicio,
    input  LX, LS, LP, H, M_S, IDX, ocupado, pronto
  );
endinterface

// File: rtl/controle_horner.sv
// Horner-rule sequencer for the polynomial-evaluation datapath.
// Evaluates S = (((a_N*x + a_(N-1))*x + ...)*x + a_0) over GRAU+1 coefficients,
// waiting MUL_LAT cycles per multiplication, with a start/done handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : controle_horner_if.master
//          inicio (in)  start request, level-sensitive
//          LX/LS/LP     X, S and product register loads
//          H            multiplier enable
//          M_S          S source: 0 = coef[IDX], 1 = P + coef[IDX]
//          IDX          coefficient read address
//          ocupado      run in progress
//          pronto       result valid in S
module controle_horner #(
  parameter int unsigned GRAU    = 3,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  controle_horner_if.master  bus
);

  localparam int unsigned CNT_W = (MUL_LAT + 1 > 1) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(GRAU);
  // LP coincides with the first MULT cycle only for a single-cycle multiplier
  localparam logic LP_ON_ENTRY = (MUL_LAT == 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARGA_X = 3'd1,
    CARGA_S = 3'd2,
    MULT    = 3'd3,
    SOMA    = 3'd4,
    PRONTO  = 3'd5
  } estado_t;

  estado_t          estado;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic lx_r, ls_r, lp_r, h_r, ms_r, ocupado_r, pronto_r;

  // State, counters and Moore outputs; outputs are registered from the
  // state being entered so they line up with that state's cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= OCIOSO;
      idx       <= '0;
      cnt       <= '0;
      lx_r      <= 1'b0;
      ls_r      <= 1'b0;
      lp_r      <= 1'b0;
      h_r       <= 1'b0;
      ms_r      <= 1'b0;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
    end else begin
      lx_r      <= 1'b0;
      ls_r      <= 1'b0;
      lp_r      <= 1'b0;
      h_r       <= 1'b0;
      ms_r      <= 1'b0;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.inicio) begin
            estado    <= CARGA_X;
            idx       <= IDX_TOP;
            lx_r      <= 1'b1;
            ocupado_r <= 1'b1;
          end
        end
        CARGA_X: begin
          estado    <= CARGA_S;
          ls_r      <= 1'b1;
          ocupado_r <= 1'b1;
        end
        CARGA_S: begin
          if (GRAU == 0) begin
            estado   <= PRONTO;
            pronto_r <= 1'b1;
          end else begin
            estado    <= MULT;
            idx       <= idx - 1'b1;
            cnt       <= '0;
            h_r       <= 1'b1;
            lp_r      <= LP_ON_ENTRY;
            ocupado_r <= 1'b1;
          end
        end
        MULT: begin
          cnt       <= cnt + 1'b1;
          ocupado_r <= 1'b1;
          if (cnt == CNT_LAST) begin
            estado <= SOMA;
            ls_r   <= 1'b1;
            ms_r   <= 1'b1;
          end else begin
            h_r  <= 1'b1;
            lp_r <= (CNT_W'(cnt + 1'b1) == CNT_LAST);
          end
        end
        SOMA: begin
          if (idx == '0) begin
            estado   <= PRONTO;
            pronto_r <= 1'b1;
          end else begin
            estado    <= MULT;
            idx       <= idx - 1'b1;
            cnt       <= '0;
            h_r       <= 1'b1;
            lp_r      <= LP_ON_ENTRY;
            ocupado_r <= 1'b1;
          end
        end
        PRONTO: begin
          // Hold the result until the requester drops inicio
          if (bus.inicio) begin
            pronto_r <= 1'b1;
          end else begin
            estado <= OCIOSO;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.LX      = lx_r;
  assign bus.LS      = ls_r;
  assign bus.LP      = lp_r;
  assign bus.H       = h_r;
  assign bus.M_S     = ms_r;
  assign bus.IDX     = idx;
  assign bus.ocupado = ocupado_r;
  assign bus.pronto  = pronto_r;

endmodule
